// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC chain sequencer: FSM state encoding, size-field
// width and the saturate/ReLU output function.
package fc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StMac,
    StDrain,
    StWrite,
    StLend,
    StDone
  } fc_state_e;

  localparam int unsigned SizeW     = 16;
  localparam int unsigned MaxLayers = 4;
  localparam int unsigned SatW      = 64;

  // Clamp v to the signed dw-bit range, then optionally zero negatives.
  function automatic logic signed [SatW-1:0] sat_relu(input logic signed [SatW-1:0] v,
                                                      input int unsigned dw,
                                                      input logic relu);
    logic signed [SatW-1:0] hi, lo, r;
    hi = $signed((64'd1 << (dw - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    if (relu && (r < 0)) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_sat.sv
// Signed Q-format accumulator fed by 1-cycle-latency RAM data, with a
// shift/saturate/ReLU result stage.
module fc_mac_sat
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bias_iss,
  input  logic              i_mac_iss,
  input  logic              i_relu,
  input  logic [DATA_W-1:0] i_act,
  input  logic [DATA_W-1:0] i_wgt,
  output logic [DATA_W-1:0] o_res
);

  logic                       r_bias_v, r_mac_v;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_bias, w_shift;

  assign w_prod  = $signed(i_act) * $signed(i_wgt);
  assign w_bias  = ACC_W'($signed(i_wgt)) <<< FRAC_W;
  assign w_shift = r_acc >>> FRAC_W;
  assign o_res   = DATA_W'(sat_relu(SatW'(w_shift), DATA_W, i_relu));

  // Issue strobes are delayed one cycle to line up with the RAM read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bias_v <= 1'b0;
      r_mac_v  <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_bias_v <= i_bias_iss;
      r_mac_v  <= i_mac_iss;
      if (r_bias_v) begin
        r_acc <= w_bias;
      end else if (r_mac_v) begin
        r_acc <= r_acc + ACC_W'(w_prod);
      end
    end
  end

endmodule

// File: rtl/fc_chain_seq.sv
// Time-multiplexed FC layer chain: one MAC, ping-pong activation regions and a linear
// weight stream (bias then N_in weights per output neuron).
module fc_chain_seq
  import fc_pkg::*;
#(
  parameter int unsigned          NUM_LAYERS  = 2,
  parameter logic [5*SizeW-1:0]   LAYER_SIZES = {16'd0, 16'd0, 16'd10, 16'd20, 16'd32},
  parameter int unsigned          DATA_W      = 16,
  parameter int unsigned          FRAC_W      = 8,
  parameter int unsigned          ACC_W       = 40,
  parameter int unsigned          ADDR_W      = 16,
  parameter int unsigned          ACT_BASE    = 0,
  parameter int unsigned          ACT_STRIDE  = 256,
  parameter int unsigned          WGT_BASE    = 0,
  parameter bit                   RELU_LAST   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              layer_end,
  output logic [1:0]        layer_idx,
  output logic              act_re,
  output logic [ADDR_W-1:0] act_raddr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic              w_re,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] RegA      = ADDR_W'(ACT_BASE);
  localparam logic [ADDR_W-1:0] RegB      = ADDR_W'(ACT_BASE + ACT_STRIDE);
  localparam logic [ADDR_W-1:0] WgtStart  = ADDR_W'(WGT_BASE);
  localparam logic [1:0]        LastLayer = 2'(NUM_LAYERS - 1);

  fc_state_e         r_state;
  logic [1:0]        r_layer;
  logic [SizeW-1:0]  r_neuron, r_idx;
  logic [ADDR_W-1:0] r_wptr, r_act_raddr, r_w_addr, r_wr_addr;
  logic              r_busy, r_done, r_lend, r_act_re, r_w_re, r_we;

  logic [SizeW-1:0]  w_n_in, w_n_out;
  logic [ADDR_W-1:0] w_in_base, w_out_base;
  logic              w_relu;
  logic [DATA_W-1:0] w_res;

  assign w_n_in     = LAYER_SIZES[SizeW*32'(r_layer) +: SizeW];
  assign w_n_out    = LAYER_SIZES[SizeW*(32'(r_layer) + 1) +: SizeW];
  assign w_in_base  = r_layer[0] ? RegB : RegA;
  assign w_out_base = r_layer[0] ? RegA : RegB;
  assign w_relu     = (r_layer != LastLayer) || RELU_LAST;

  fc_mac_sat #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_bias_iss(r_w_re & ~r_act_re),
    .i_mac_iss (r_act_re),
    .i_relu    (w_relu),
    .i_act     (act_rdata),
    .i_wgt     (w_rdata),
    .o_res     (w_res)
  );

  // Outputs are registered: each transition loads the strobes for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_layer     <= '0;
      r_neuron    <= '0;
      r_idx       <= '0;
      r_wptr      <= WgtStart;
      r_act_raddr <= '0;
      r_w_addr    <= '0;
      r_wr_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lend      <= 1'b0;
      r_act_re    <= 1'b0;
      r_w_re      <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state  <= StBias;
            r_busy   <= 1'b1;
            r_layer  <= '0;
            r_neuron <= '0;
            r_w_re   <= 1'b1;
            r_w_addr <= WgtStart;
            r_wptr   <= WgtStart + ADDR_W'(1);
          end
        end
        StBias: begin
          r_state     <= StMac;
          r_idx       <= '0;
          r_act_re    <= 1'b1;
          r_act_raddr <= w_in_base;
          r_w_addr    <= r_wptr;
          r_wptr      <= r_wptr + ADDR_W'(1);
        end
        StMac: begin
          if (r_idx == w_n_in - SizeW'(1)) begin
            r_state  <= StDrain;
            r_act_re <= 1'b0;
            r_w_re   <= 1'b0;
          end else begin
            r_idx       <= r_idx + SizeW'(1);
            r_act_raddr <= w_in_base + ADDR_W'(r_idx) + ADDR_W'(1);
            r_w_addr    <= r_wptr;
            r_wptr      <= r_wptr + ADDR_W'(1);
          end
        end
        StDrain: begin
          r_state   <= StWrite;
          r_we      <= 1'b1;
          r_wr_addr <= w_out_base + ADDR_W'(r_neuron);
        end
        StWrite: begin
          r_we <= 1'b0;
          if (r_neuron != w_n_out - SizeW'(1)) begin
            r_state  <= StBias;
            r_neuron <= r_neuron + SizeW'(1);
            r_w_re   <= 1'b1;
            r_w_addr <= r_wptr;
            r_wptr   <= r_wptr + ADDR_W'(1);
          end else begin
            r_state <= StLend;
            r_lend  <= 1'b1;
          end
        end
        StLend: begin
          r_lend <= 1'b0;
          if (r_layer != LastLayer) begin
            r_state  <= StBias;
            r_layer  <= r_layer + 2'd1;
            r_neuron <= '0;
            r_w_re   <= 1'b1;
            r_w_addr <= r_wptr;
            r_wptr   <= r_wptr + ADDR_W'(1);
          end else begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign layer_end = r_lend;
  assign layer_idx = r_layer;
  assign act_re    = r_act_re;
  assign act_raddr = r_act_raddr;
  assign w_re      = r_w_re;
  assign w_addr    = r_w_addr;
  assign we        = r_we;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_we ? w_res : '0;

endmodule
